// File: rtl/imem_prog.sv
// ---------------------------------------------------------------------------
// imem_prog
//
// Byte-programmable instruction memory with a combinational, big-endian
// word fetch port. A programming session is opened with prog_start and fed
// one byte per cycle through a valid/ready handshake. The last byte of a
// session is flagged with prog_last, and the session ends with a one-cycle
// prog_done pulse.
//
// Optional feature macro: IMEM_PROG_CLEAR_EN
//   defined   - each session first rewrites every word with NOP_WORD
//               (CLEAR state, MEM_DEPTH_BYTES/4 extra cycles).
//   undefined - sessions go straight to loading; bytes that are not
//               reloaded keep their previous contents.
//
// Ports
//   clk           clock
//   rst_n         asynchronous active-low reset (memory contents untouched)
//   a             fetch byte address
//   rd            fetched instruction {mem[a], mem[a+1], mem[a+2], mem[a+3]}
//   misaligned    a[1:0] != 0
//   out_of_range  a+3 >= MEM_DEPTH_BYTES
//   prog_start    open (or restart) a programming session
//   prog_valid    prog_byte is valid
//   prog_byte     byte to load
//   prog_last     final byte of the session (only meaningful with prog_valid)
//   prog_ready    loader accepts a byte this cycle
//   busy          session in progress (CLEAR, LOAD or DONE)
//   prog_done     one-cycle session-complete pulse
//   prog_overflow sticky: a byte was offered past capacity
//   prog_count    bytes written during the current session
// ---------------------------------------------------------------------------
module imem_prog #(
    parameter int                        ADDR_BUS_WIDTH  = 16,
    parameter int                        DATA_BUS_WIDTH  = 32,
    parameter int                        MEM_DEPTH_BYTES = 128,
    parameter logic [DATA_BUS_WIDTH-1:0] NOP_WORD        = 32'h00000013
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [ADDR_BUS_WIDTH-1:0]          a,
    output logic [DATA_BUS_WIDTH-1:0]          rd,
    output logic                               misaligned,
    output logic                               out_of_range,
    input  logic                               prog_start,
    input  logic                               prog_valid,
    input  logic [7:0]                         prog_byte,
    input  logic                               prog_last,
    output logic                               prog_ready,
    output logic                               busy,
    output logic                               prog_done,
    output logic                               prog_overflow,
    output logic [$clog2(MEM_DEPTH_BYTES):0]   prog_count
);

    localparam int WORDS   = MEM_DEPTH_BYTES / 4;
    localparam int BYTE_AW = $clog2(MEM_DEPTH_BYTES);
    localparam int WORD_AW = BYTE_AW - 2;
    localparam int CNT_W   = BYTE_AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        LOAD  = 2'd2,
        DONE  = 2'd3
    } state_t;

`ifdef IMEM_PROG_CLEAR_EN
    localparam state_t START_STATE = CLEAR;
`else
    localparam state_t START_STATE = LOAD;
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   ptr_q, ptr_d;
    logic               overflow_q, overflow_d;
    logic               byteWe;
`ifdef IMEM_PROG_CLEAR_EN
    logic [WORD_AW-1:0] clearIdx_q, clearIdx_d;
    logic               clearWe;
`endif

    // Word-organised storage; byte 0 of a word lives in bits [31:24] so an
    // aligned fetch is simply the stored word. The power-up image is all
    // NOP_WORD and is deliberately outside the reset domain.
    logic [DATA_BUS_WIDTH-1:0] mem_q [WORDS] = '{default: NOP_WORD};

    // Control state. The write pointer doubles as the session byte count,
    // since both are cleared together and advance on the same writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            overflow_q <= 1'b0;
`ifdef IMEM_PROG_CLEAR_EN
            clearIdx_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            overflow_q <= overflow_d;
`ifdef IMEM_PROG_CLEAR_EN
            clearIdx_q <= clearIdx_d;
`endif
        end
    end

    // Next-state logic. prog_start outside DONE (re)opens a session and
    // takes priority over any byte offered in the same cycle.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        overflow_d = overflow_q;
        byteWe     = 1'b0;
`ifdef IMEM_PROG_CLEAR_EN
        clearIdx_d = clearIdx_q;
        clearWe    = 1'b0;
`endif
        if (prog_start && (state_q != DONE)) begin
            state_d    = START_STATE;
            ptr_d      = '0;
            overflow_d = 1'b0;
`ifdef IMEM_PROG_CLEAR_EN
            clearIdx_d = '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
`ifdef IMEM_PROG_CLEAR_EN
                CLEAR: begin
                    clearWe = 1'b1;
                    if (clearIdx_q == WORD_AW'(WORDS - 1)) begin
                        state_d = LOAD;
                    end else begin
                        clearIdx_d = clearIdx_q + WORD_AW'(1);
                    end
                end
`endif
                LOAD: begin
                    if (prog_valid) begin
                        // A full memory drops the byte instead of wrapping.
                        if (ptr_q == CNT_W'(MEM_DEPTH_BYTES)) begin
                            overflow_d = 1'b1;
                        end else begin
                            byteWe = 1'b1;
                            ptr_d  = ptr_q + CNT_W'(1);
                        end
                        if (prog_last) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Memory writes: whole NOP words while clearing, single byte lanes
    // while loading.
    always_ff @(posedge clk) begin
`ifdef IMEM_PROG_CLEAR_EN
        if (clearWe) begin
            mem_q[clearIdx_q] <= NOP_WORD;
        end else
`endif
        if (byteWe) begin
            case (ptr_q[1:0])
                2'd0:    mem_q[ptr_q[BYTE_AW-1:2]][31:24] <= prog_byte;
                2'd1:    mem_q[ptr_q[BYTE_AW-1:2]][23:16] <= prog_byte;
                2'd2:    mem_q[ptr_q[BYTE_AW-1:2]][15:8]  <= prog_byte;
                default: mem_q[ptr_q[BYTE_AW-1:2]][7:0]   <= prog_byte;
            endcase
        end
    end

    // Status outputs decoded from the state register.
    assign prog_ready    = (state_q == LOAD);
    assign busy          = (state_q != IDLE);
    assign prog_done     = (state_q == DONE);
    assign prog_overflow = overflow_q;
    assign prog_count    = ptr_q;

    // Range check is done one bit wider so a+3 cannot wrap near the top of
    // the address space.
    assign misaligned   = |a[1:0];
    assign out_of_range = (({1'b0, a} + (ADDR_BUS_WIDTH+1)'(3)) >=
                           (ADDR_BUS_WIDTH+1)'(MEM_DEPTH_BYTES));

    // Fetch returns NOP_WORD whenever the addressed word is not safely
    // readable, including while a session is rewriting memory.
    always_comb begin
        rd = NOP_WORD;
        if (!busy && !misaligned && !out_of_range) begin
            rd = mem_q[a[BYTE_AW-1:2]];
        end
    end

endmodule

// File: tb/tb_imem_prog.sv
// ---------------------------------------------------------------------------
// tb_imem_prog
//
// Directed self-checking bench for imem_prog at default parameters
// (16-bit address, 32-bit data, 128 bytes, NOP 32'h00000013). Expected
// values that depend on IMEM_PROG_CLEAR_EN are selected with the same macro.
// ---------------------------------------------------------------------------
module tb_imem_prog;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [31:0] rd;
    logic        misaligned;
    logic        out_of_range;
    logic        prog_start;
    logic        prog_valid;
    logic [7:0]  prog_byte;
    logic        prog_last;
    logic        prog_ready;
    logic        busy;
    logic        prog_done;
    logic        prog_overflow;
    logic [7:0]  prog_count;

    int checks;
    int failures;

    imem_prog dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .a             (a),
        .rd            (rd),
        .misaligned    (misaligned),
        .out_of_range  (out_of_range),
        .prog_start    (prog_start),
        .prog_valid    (prog_valid),
        .prog_byte     (prog_byte),
        .prog_last     (prog_last),
        .prog_ready    (prog_ready),
        .busy          (busy),
        .prog_done     (prog_done),
        .prog_overflow (prog_overflow),
        .prog_count    (prog_count)
    );

    // 10 ns clock; inputs change 1 ns after each rising edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offers one byte for exactly one clock edge.
    task automatic applyStimulus(input logic [7:0] b, input logic last);
        prog_valid = 1'b1;
        prog_byte  = b;
        prog_last  = last;
        @(posedge clk);
        #1;
        prog_valid = 1'b0;
        prog_last  = 1'b0;
    endtask

    // Waits (bounded) until the loader is ready to accept bytes.
    task automatic waitLoad(input string name);
        int n;
        n = 0;
        while (prog_ready !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (prog_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL %s_wait_load: prog_ready=%b required 1 after %0d cycles", name, prog_ready, n);
        end
    endtask

    // Opens a session with a one-cycle prog_start pulse.
    task automatic startSession(input string name);
        prog_start = 1'b1;
        @(posedge clk);
        #1;
        prog_start = 1'b0;
        waitLoad(name);
    endtask

    task automatic test_reset;
        rst_n      = 1'b0;
        a          = 16'd0;
        prog_start = 1'b0;
        prog_valid = 1'b0;
        prog_byte  = 8'd0;
        prog_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (rd !== NOP) begin
            failures++;
            $display("[TB] FAIL reset_rd: got %h required %h", rd, NOP);
        end
        checks++;
        if (busy !== 1'b0 || prog_ready !== 1'b0 || prog_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_status: busy=%b ready=%b done=%b required 0 0 0", busy, prog_ready, prog_done);
        end
        checks++;
        if (prog_count !== 8'd0 || prog_overflow !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_count: count=%0d ovf=%b required 0 0", prog_count, prog_overflow);
        end
    endtask

    task automatic test_basic_load;
        startSession("basic");
        checks++;
        if (busy !== 1'b1 || prog_count !== 8'd0) begin
            failures++;
            $display("[TB] FAIL basic_open: busy=%b count=%0d required 1 0", busy, prog_count);
        end
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h81, 1'b0);
        a = 16'd0;
        #1;
        checks++;
        if (prog_count !== 8'd3 || rd !== NOP) begin
            failures++;
            $display("[TB] FAIL basic_mid: count=%0d rd=%h required 3 %h", prog_count, rd, NOP);
        end
        applyStimulus(8'h33, 1'b1);
        checks++;
        if (prog_done !== 1'b1 || prog_count !== 8'd4 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL basic_done: done=%b count=%0d busy=%b required 1 4 1", prog_done, prog_count, busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (prog_done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_pulse_end: done=%b busy=%b required 0 0", prog_done, busy);
        end
        a = 16'd0;
        #1;
        checks++;
        if (rd !== 32'h00008133 || misaligned !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_fetch: rd=%h mis=%b required 00008133 0", rd, misaligned);
        end
        a = 16'd2;
        #1;
        checks++;
        if (misaligned !== 1'b1 || rd !== NOP) begin
            failures++;
            $display("[TB] FAIL basic_misaligned: mis=%b rd=%h required 1 %h", misaligned, rd, NOP);
        end
    endtask

    task automatic test_overflow;
        startSession("overflow");
        for (int i = 0; i < 128; i++) begin
            applyStimulus(8'(i + 1), 1'b0);
        end
        checks++;
        if (prog_count !== 8'd128 || prog_overflow !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ovf_full: count=%0d ovf=%b required 128 0", prog_count, prog_overflow);
        end
        applyStimulus(8'hEE, 1'b1);
        checks++;
        if (prog_overflow !== 1'b1 || prog_count !== 8'd128 || prog_done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ovf_extra: ovf=%b count=%0d done=%b required 1 128 1", prog_overflow, prog_count, prog_done);
        end
        @(posedge clk);
        #1;
        a = 16'd0;
        #1;
        checks++;
        if (rd !== 32'h01020304 || prog_overflow !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ovf_word0: rd=%h ovf=%b required 01020304 1", rd, prog_overflow);
        end
        a = 16'd124;
        #1;
        checks++;
        if (out_of_range !== 1'b0 || rd !== 32'h7D7E7F80) begin
            failures++;
            $display("[TB] FAIL range_124: oor=%b rd=%h required 0 7d7e7f80", out_of_range, rd);
        end
        a = 16'd125;
        #1;
        checks++;
        if (out_of_range !== 1'b1 || rd !== NOP) begin
            failures++;
            $display("[TB] FAIL range_125: oor=%b rd=%h required 1 %h", out_of_range, rd, NOP);
        end
    endtask

    task automatic test_clear_option;
        logic [31:0] expWord8;
`ifdef IMEM_PROG_CLEAR_EN
        expWord8 = NOP;
`else
        expWord8 = 32'h01010101;
`endif
        startSession("clear_pre");
        checks++;
        if (prog_overflow !== 1'b0) begin
            failures++;
            $display("[TB] FAIL clear_ovf_reset: ovf=%b required 0", prog_overflow);
        end
        for (int i = 0; i < 12; i++) begin
            applyStimulus((i < 8) ? 8'hAA : 8'h01, i == 11);
        end
        @(posedge clk);
        #1;
        a = 16'd8;
        #1;
        checks++;
        if (rd !== 32'h01010101) begin
            failures++;
            $display("[TB] FAIL clear_preload: rd=%h required 01010101", rd);
        end
        startSession("clear_new");
        applyStimulus(8'h11, 1'b0);
        applyStimulus(8'h22, 1'b0);
        applyStimulus(8'h33, 1'b0);
        applyStimulus(8'h44, 1'b1);
        @(posedge clk);
        #1;
        a = 16'd0;
        #1;
        checks++;
        if (rd !== 32'h11223344) begin
            failures++;
            $display("[TB] FAIL clear_word0: rd=%h required 11223344", rd);
        end
        a = 16'd8;
        #1;
        checks++;
        if (rd !== expWord8) begin
            failures++;
            $display("[TB] FAIL clear_word8: rd=%h required %h", rd, expWord8);
        end
    endtask

    task automatic test_reset_mid_load;
        logic [31:0] expWord0;
`ifdef IMEM_PROG_CLEAR_EN
        expWord0 = 32'h55660013;
`else
        expWord0 = 32'h55663344;
`endif
        startSession("rstmid");
        applyStimulus(8'h55, 1'b0);
        applyStimulus(8'h66, 1'b0);
        checks++;
        if (prog_count !== 8'd2) begin
            failures++;
            $display("[TB] FAIL rstmid_count: count=%0d required 2", prog_count);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || prog_count !== 8'd0 || prog_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rstmid_async: busy=%b count=%0d ready=%b required 0 0 0", busy, prog_count, prog_ready);
        end
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        a = 16'd0;
        #1;
        checks++;
        if (rd !== expWord0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rstmid_kept: rd=%h busy=%b required %h 0", rd, busy, expWord0);
        end
    endtask

    task automatic test_back_to_back;
        startSession("restart");
        applyStimulus(8'h77, 1'b0);
        checks++;
        if (prog_count !== 8'd1) begin
            failures++;
            $display("[TB] FAIL restart_pre: count=%0d required 1", prog_count);
        end
        prog_start = 1'b1;
        prog_valid = 1'b1;
        prog_byte  = 8'h99;
        @(posedge clk);
        #1;
        prog_start = 1'b0;
        prog_valid = 1'b0;
        checks++;
        if (prog_count !== 8'd0 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL restart_drop: count=%0d busy=%b required 0 1", prog_count, busy);
        end
        waitLoad("restart");
        prog_last = 1'b1;
        @(posedge clk);
        #1;
        prog_last = 1'b0;
        checks++;
        if (prog_ready !== 1'b1 || prog_done !== 1'b0 || prog_count !== 8'd0) begin
            failures++;
            $display("[TB] FAIL last_no_valid: ready=%b done=%b count=%0d required 1 0 0", prog_ready, prog_done, prog_count);
        end
        applyStimulus(8'hAB, 1'b0);
        applyStimulus(8'hCD, 1'b0);
        applyStimulus(8'hEF, 1'b0);
        applyStimulus(8'h01, 1'b1);
        checks++;
        if (prog_done !== 1'b1 || prog_count !== 8'd4) begin
            failures++;
            $display("[TB] FAIL restart_done: done=%b count=%0d required 1 4", prog_done, prog_count);
        end
        @(posedge clk);
        #1;
        a = 16'd0;
        #1;
        checks++;
        if (rd !== 32'hABCDEF01) begin
            failures++;
            $display("[TB] FAIL restart_word0: rd=%h required abcdef01", rd);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset;
        test_basic_load;
        test_overflow;
        test_clear_option;
        test_reset_mid_load;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_prog.md
IMEM_PROG -- requirements
Module: imem_prog

Interface
REQ-001 The block SHALL have parameter ADDR_BUS_WIDTH, default 16, fetch address width.
REQ-002 The block SHALL have parameter DATA_BUS_WIDTH, default 32, instruction width (fixed 4 bytes).
REQ-003 The block SHALL have parameter MEM_DEPTH_BYTES, default 128, byte capacity (power of 2, multiple of 4).
REQ-004 The block SHALL have parameter NOP_WORD, default 32'h00000013, fill/stall word.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-006 The ports SHALL be, in order:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- a  in  ADDR_BUS_WIDTH  fetch byte address
- rd  out  DATA_BUS_WIDTH  fetched instruction
- misaligned  out  1  a[1:0] != 0
- out_of_range  out  1  a+3 >= MEM_DEPTH_BYTES
- prog_start  in  1  begin programming session
- prog_valid  in  1  prog_byte valid
- prog_byte  in  8  load byte
- prog_last  in  1  final byte of session
- prog_ready  out  1  byte accepted this cycle when valid
- busy  out  1  session in progress
- prog_done  out  1  one-cycle session-complete pulse
- prog_overflow  out  1  sticky: byte offered past capacity
- prog_count  out  clog2(MEM_DEPTH_BYTES)+1  bytes written this session

Function
REQ-007 The FSM SHALL have states IDLE, CLEAR, LOAD, DONE.
REQ-008 IDLE: prog_start=1 -> CLEAR (if IMEM_PROG_CLEAR_EN) else LOAD; next cycle zeroes prog_count and write pointer and clears prog_overflow.
REQ-009 CLEAR: one word per cycle written with NOP_WORD, ascending from 0; after word MEM_DEPTH_BYTES/4-1 -> LOAD.
REQ-010 LOAD: prog_ready=1; prog_valid=1 writes prog_byte to memory[ptr], ptr and prog_count increment.
REQ-011 LOAD with prog_valid=1 and ptr=MEM_DEPTH_BYTES: byte dropped, prog_overflow set, no wrap.
REQ-012 LOAD with prog_valid=1 and prog_last=1: byte written (subject to REQ-011), -> DONE.
REQ-013 DONE: prog_done=1 for exactly one cycle, -> IDLE.
REQ-014 prog_start in CLEAR or LOAD SHALL restart the session (REQ-008); a simultaneous prog_valid byte is dropped.
REQ-015 prog_last without prog_valid SHALL be ignored.
REQ-016 busy=1 in CLEAR, LOAD, DONE; prog_ready=0 outside LOAD.
REQ-017 Fetch is combinational, big-endian: rd = {mem[a], mem[a+1], mem[a+2], mem[a+3]}.
REQ-018 rd SHALL equal NOP_WORD when busy=1, misaligned=1 or out_of_range=1.
REQ-019 Memory SHALL initialise (initial block) to NOP_WORD in every word.

Reset
REQ-020 rst_n=0 SHALL asynchronously force: state IDLE, ptr 0, prog_count 0, prog_ready 0, busy 0, prog_done 0, prog_overflow 0.
REQ-021 Reset SHALL NOT alter memory contents; reset mid-LOAD keeps bytes already written.

Configuration
REQ-022 Macro IMEM_PROG_CLEAR_EN defined: CLEAR state present, session costs MEM_DEPTH_BYTES/4 extra cycles, unloaded bytes read as NOP_WORD.
REQ-023 Macro IMEM_PROG_CLEAR_EN undefined: CLEAR state absent, prog_start -> LOAD directly, unloaded bytes keep prior contents.

Verification
REQ-024 After reset, a=0 -> rd=32'h00000013, busy=0, prog_count=0.
REQ-025 start; bytes 00,00,81,33 (last on 4th) -> prog_done pulse once, prog_count=4, a=0 -> rd=32'h00008133; a=2 -> misaligned=1, rd=NOP_WORD.
REQ-026 Load 129 bytes at depth 128 -> prog_overflow=1, prog_count=128, memory[0] unchanged by 129th byte.
REQ-027 Defined IMEM_PROG_CLEAR_EN: preload a=8 with 32'h01010101, new 4-byte session -> a=8 reads 32'h00000013; undefined -> reads 32'h01010101.
REQ-028 rst_n low after 2 of 4 bytes -> state IDLE, prog_count=0, busy=0; the 2 bytes remain readable.
REQ-029 prog_start with prog_valid in LOAD -> byte dropped, prog_count=0 next cycle; a=124 -> out_of_range=0, a=125 -> out_of_range=1.
